branch_predictor: RTL and testbench

- IF-stage branch target buffer with a 2-bit saturating direction predictor.
- Produces a taken/not-taken prediction and a next-PC target for the fetch PC.
- Consumes the ID-stage branch resolution, i.e. the comparator's taken/not-taken decision plus the computed target.
- Flags a misprediction and supplies the corrected PC for the ID-stage flush.
- Keeps branch and mispredict statistics counters.

---
 rtl/branch_predictor.sv | 98 +++++++++
 tb/tb_branch_predictor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// IF-stage branch target buffer with 2-bit saturating direction counters.
// Resolves ID-stage branches, flags mispredicts and keeps statistics.
module branch_predictor #(
    parameter int IDX_BITS = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IF_PC,
    output logic        IF_PredTaken,
    output logic [31:0] IF_PredTarget,
    input  logic        ID_Valid,
    input  logic [31:0] ID_PC,
    input  logic        ID_Taken,
    input  logic [31:0] ID_Target,
    input  logic        ID_PredTaken,
    input  logic [31:0] ID_PredTarget,
    output logic        Mispredict,
    output logic [31:0] CorrectPC,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredictCount
);

    localparam int N     = 1 << IDX_BITS;
    localparam int TAG_W = 32 - IDX_BITS - 2;

    logic             r_valid  [N];
    logic [TAG_W-1:0] r_tag    [N];
    logic [31:0]      r_target [N];
    logic [1:0]       r_ctr    [N];
    logic [31:0]      r_branch_cnt;
    logic [31:0]      r_mispred_cnt;

    logic [IDX_BITS-1:0] w_if_idx;
    logic [TAG_W-1:0]    w_if_tag;
    logic                w_if_hit;
    logic [IDX_BITS-1:0] w_id_idx;
    logic [TAG_W-1:0]    w_id_tag;
    logic                w_id_hit;
    logic                w_mispredict;

    assign w_if_idx = IF_PC[IDX_BITS+1:2];
    assign w_if_tag = IF_PC[31:IDX_BITS+2];
    assign w_id_idx = ID_PC[IDX_BITS+1:2];
    assign w_id_tag = ID_PC[31:IDX_BITS+2];

    // Zero-latency lookup from registered state; no bypass of a same-cycle update.
    always_comb begin
        w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
        IF_PredTaken  = w_if_hit && r_ctr[w_if_idx][1];
        IF_PredTarget = IF_PredTaken ? r_target[w_if_idx] : IF_PC + 32'd4;
    end

    // Resolution: wrong direction, or right direction but wrong target.
    always_comb begin
        w_id_hit     = r_valid[w_id_idx] && (r_tag[w_id_idx] == w_id_tag);
        w_mispredict = ID_Valid &&
                       ((ID_Taken != ID_PredTaken) ||
                        (ID_Taken && ID_PredTaken && (ID_Target != ID_PredTarget)));
        Mispredict   = w_mispredict;
        CorrectPC    = ID_Taken ? ID_Target : ID_PC + 32'd4;
    end

    assign BranchCount     = r_branch_cnt;
    assign MispredictCount = r_mispred_cnt;

    // Table training and statistics on each resolved branch.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (ID_Valid) begin
            if (w_id_hit) begin
                if (ID_Taken) begin
                    if (r_ctr[w_id_idx] != 2'b11) begin
                        r_ctr[w_id_idx] <= r_ctr[w_id_idx] + 2'b01;
                    end
                    r_target[w_id_idx] <= ID_Target;
                end else if (r_ctr[w_id_idx] != 2'b00) begin
                    r_ctr[w_id_idx] <= r_ctr[w_id_idx] - 2'b01;
                end
            end else if (ID_Taken) begin
                r_valid[w_id_idx]  <= 1'b1;
                r_tag[w_id_idx]    <= w_id_tag;
                r_target[w_id_idx] <= ID_Target;
                r_ctr[w_id_idx]    <= 2'b10;
            end
            r_branch_cnt  <= r_branch_cnt + 32'd1;
            r_mispred_cnt <= r_mispred_cnt + {31'd0, w_mispredict};
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios then random traffic,
// checked against an array-based reference model.
module tb_branch_predictor;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] IF_PC;
    logic        IF_PredTaken;
    logic [31:0] IF_PredTarget;
    logic        ID_Valid;
    logic [31:0] ID_PC;
    logic        ID_Taken;
    logic [31:0] ID_Target;
    logic        ID_PredTaken;
    logic [31:0] ID_PredTarget;
    logic        Mispredict;
    logic [31:0] CorrectPC;
    logic [31:0] BranchCount;
    logic [31:0] MispredictCount;

    int checks = 0;
    int failures = 0;

    // Reference model: 16 entries, strength as a plain integer 0..3.
    bit          m_valid [16];
    longint      m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_str   [16];
    longint      m_bc;
    longint      m_mc;

    branch_predictor #(.IDX_BITS(4)) dut (
        .Clk(Clk), .Reset(Reset), .IF_PC(IF_PC),
        .IF_PredTaken(IF_PredTaken), .IF_PredTarget(IF_PredTarget),
        .ID_Valid(ID_Valid), .ID_PC(ID_PC), .ID_Taken(ID_Taken),
        .ID_Target(ID_Target), .ID_PredTaken(ID_PredTaken),
        .ID_PredTarget(ID_PredTarget), .Mispredict(Mispredict),
        .CorrectPC(CorrectPC), .BranchCount(BranchCount),
        .MispredictCount(MispredictCount)
    );

    always #5 Clk = ~Clk;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic longint m_tg(input logic [31:0] pc);
        return longint'(pc / 64);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tg(pc));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_str[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_str[i]   = 1;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One cycle: drive after negedge, check mid-cycle, update model at posedge.
    task automatic step(input logic [31:0] ifpc, input bit v,
                        input logic [31:0] pc, input bit tk,
                        input logic [31:0] tg, input bit pt,
                        input logic [31:0] ptg, input string name);
        bit mis;
        int k;
        IF_PC = ifpc; ID_Valid = v; ID_PC = pc; ID_Taken = tk;
        ID_Target = tg; ID_PredTaken = pt; ID_PredTarget = ptg;
        #2;
        mis = v && ((tk != pt) || (tk && pt && tg != ptg));
        chk({name, ".pt"}, {31'd0, IF_PredTaken}, {31'd0, m_pred(ifpc)});
        chk({name, ".ptgt"}, IF_PredTarget, m_ptgt(ifpc));
        chk({name, ".mis"}, {31'd0, Mispredict}, {31'd0, mis});
        if (v) chk({name, ".cpc"}, CorrectPC, tk ? tg : pc + 32'd4);
        chk({name, ".bc"}, BranchCount, m_bc[31:0]);
        chk({name, ".mc"}, MispredictCount, m_mc[31:0]);
        @(posedge Clk);
        if (v) begin
            k = m_idx(pc);
            if (m_hit(pc)) begin
                if (tk) begin
                    m_str[k] = (m_str[k] + 1 > 3) ? 3 : m_str[k] + 1;
                    m_tgt[k] = tg;
                end else begin
                    m_str[k] = (m_str[k] - 1 < 0) ? 0 : m_str[k] - 1;
                end
            end else if (tk) begin
                m_valid[k] = 1;
                m_tag[k]   = m_tg(pc);
                m_tgt[k]   = tg;
                m_str[k]   = 2;
            end
            m_bc++;
            if (mis) m_mc++;
        end
        @(negedge Clk);
    endtask

    localparam logic [31:0] A = 32'h0040_0020;
    localparam logic [31:0] B = 32'h0040_0060;
    localparam logic [31:0] T = 32'h0040_0040;

    initial begin
        logic [31:0] pc, ifpc, tg, ptg;
        bit tk, pt, v;

        Reset = 1'b1;
        IF_PC = 0; ID_Valid = 0; ID_PC = 0; ID_Taken = 0;
        ID_Target = 0; ID_PredTaken = 0; ID_PredTarget = 0;
        m_reset();
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        step(32'h0040_0010, 0, 0, 0, 0, 0, 0, "reset");
        chk("reset.tgt_const", IF_PredTarget, 32'h0040_0014);

        step(A, 1, A, 1, T, 0, 0, "alloc");
        IF_PC = A; ID_Valid = 0; #2;
        chk("alloc.next_pt", {31'd0, IF_PredTaken}, 32'd1);
        chk("alloc.next_tgt", IF_PredTarget, T);
        chk("alloc.counts", {BranchCount[15:0], MispredictCount[15:0]},
            32'h0001_0001);

        for (int i = 0; i < 3; i++) step(A, 1, A, 1, T, 1, T, "sat_up");
        step(A, 1, A, 0, 32'h0, 1, T, "nt1");
        step(A, 1, A, 0, 32'h0, 1, T, "nt2");
        IF_PC = A; #2;
        chk("nt2.tgt_const", IF_PredTarget, 32'h0040_0024);
        step(A, 1, A, 0, 32'h0, 1, T, "nt3");

        step(A, 1, A, 1, T, 0, 0, "realloc");
        step(B, 0, 0, 0, 0, 0, 0, "alias_miss");
        step(B, 1, B, 1, 32'h0040_0100, 0, 0, "alias_alloc");
        step(A, 0, 0, 0, 0, 0, 0, "alias_old");
        step(B, 0, 0, 0, 0, 0, 0, "alias_new");

        step(B, 1, B, 1, T, 1, 32'h0040_0044, "same_cyc");
        step(B, 0, 0, 0, 0, 0, 0, "same_next");
        chk("same_next.tgt_const", IF_PredTarget, T);

        for (int i = 0; i < 600; i++) begin
            pc   = 32'h0040_0000 + ($urandom_range(0, 47) << 2);
            ifpc = 32'h0040_0000 + ($urandom_range(0, 47) << 2);
            tg   = 32'h0041_0000 + ($urandom_range(0, 3) << 4);
            v    = ($urandom_range(0, 3) != 0);
            tk   = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) != 0) begin
                pt  = m_pred(pc);
                ptg = m_ptgt(pc);
            end else begin
                pt  = $urandom_range(0, 1) == 1;
                ptg = 32'h0041_0000 + ($urandom_range(0, 3) << 4);
            end
            step(ifpc, v, pc, tk, tg, pt, ptg, "rand");
        end

        step(A, 1, A, 1, T, 0, 0, "pre_rst");
        IF_PC = A; ID_Valid = 1; ID_PC = A; ID_Taken = 1;
        ID_Target = T; ID_PredTaken = 0;
        #2;
        Reset = 1'b1;
        #1;
        m_reset();
        chk("arst.pt", {31'd0, IF_PredTaken}, 32'd0);
        chk("arst.tgt", IF_PredTarget, A + 32'd4);
        chk("arst.bc", BranchCount, 32'd0);
        chk("arst.mc", MispredictCount, 32'd0);
        chk("arst.mis", {31'd0, Mispredict}, 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        step(A, 0, 0, 0, 0, 0, 0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
